// File: rtl/ysyx_22041752_trap_seq.sv
// rtl/ysyx_22041752_trap_seq.sv - trap/return sequencer owning the CSR-file port
module ysyx_22041752_trap_seq #(
  parameter int                     XLEN        = 64,
  parameter int                     NUM_IRQ     = 3,
  parameter logic [4*NUM_IRQ-1:0]   IRQ_CODES   = {4'd11, 4'd3, 4'd7},
  parameter bit                     VECTORED    = 1'b1,
  parameter bit                     WRITE_MTVAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               in_ecall,
  input  logic               in_ebreak,
  input  logic               in_illegal,
  input  logic               in_mret,
  input  logic [XLEN-1:0]    in_tval,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               mstatus_mie,
  input  logic               ins_csr_we,
  input  logic [11:0]        ins_csr_addr,
  input  logic [XLEN-1:0]    ins_csr_wdata,
  output logic               csr_we,
  output logic [11:0]        csr_addr,
  output logic [XLEN-1:0]    csr_wdata,
  input  logic [XLEN-1:0]    csr_rdata,
  output logic               stall,
  output logic               flush,
  output logic [XLEN-1:0]    flush_pc,
  output logic               trap_taken
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam int B_MIE  = 3;
  localparam int B_MPIE = 7;

  typedef enum logic [2:0] {
    S_IDLE, S_W_EPC, S_W_CAUSE, S_W_TVAL, S_W_STAT, S_TVEC, S_M_STAT, S_M_EPC
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [3:0]        code_q, code_d;
  logic              is_irq_q, is_irq_d;

  logic [NUM_IRQ-1:0] irq_vec;
  logic [3:0]         irq_code;
  logic               exc_hit, irq_hit, mret_hit;

  // Event detection: highest-index enabled interrupt wins, exceptions beat irqs.
  always_comb begin
    irq_vec  = irq_pending & irq_enable;
    irq_code = 4'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_vec[i]) irq_code = IRQ_CODES[4*i +: 4];
    end
    exc_hit  = in_valid & (in_illegal | in_ebreak | in_ecall);
    irq_hit  = in_valid & mstatus_mie & (|irq_vec);
    mret_hit = in_valid & in_mret & ~exc_hit & ~irq_hit;
  end

  // Next state and latched trap context; only IDLE samples new events.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tval_d   = tval_q;
    code_d   = code_q;
    is_irq_d = is_irq_q;
    case (state_q)
      S_IDLE: begin
        if (exc_hit || irq_hit) begin
          pc_d     = in_pc;
          is_irq_d = ~exc_hit;
          tval_d   = exc_hit ? in_tval : '0;
          if (in_illegal && in_valid)     code_d = 4'd2;
          else if (in_ebreak && in_valid) code_d = 4'd3;
          else if (in_ecall && in_valid)  code_d = 4'd11;
          else                            code_d = irq_code;
          state_d = S_W_EPC;
        end else if (mret_hit) begin
          state_d = S_M_STAT;
        end
      end
      S_W_EPC:   state_d = S_W_CAUSE;
      S_W_CAUSE: state_d = WRITE_MTVAL ? S_W_TVAL : S_W_STAT;
      S_W_TVAL:  state_d = S_W_STAT;
      S_W_STAT:  state_d = S_TVEC;
      S_TVEC:    state_d = S_IDLE;
      S_M_STAT:  state_d = S_M_EPC;
      S_M_EPC:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State and context registers; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      tval_q   <= '0;
      code_q   <= '0;
      is_irq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tval_q   <= tval_d;
      code_q   <= code_d;
      is_irq_q <= is_irq_d;
    end
  end

  // CSR port and redirect decode: one CSR access per state, held quiet in reset.
  always_comb begin
    csr_we     = 1'b0;
    csr_addr   = 12'h000;
    csr_wdata  = '0;
    stall      = 1'b0;
    flush      = 1'b0;
    flush_pc   = '0;
    trap_taken = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exc_hit || irq_hit || mret_hit) begin
          stall = 1'b1;
        end else if (in_valid) begin
          csr_we    = ins_csr_we;
          csr_addr  = ins_csr_addr;
          csr_wdata = ins_csr_wdata;
        end
      end
      S_W_EPC: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = A_MEPC;
        csr_wdata = {pc_q[XLEN-1:1], 1'b0};
      end
      S_W_CAUSE: begin
        stall           = 1'b1;
        csr_we          = 1'b1;
        csr_addr        = A_MCAUSE;
        csr_wdata[3:0]  = code_q;
        csr_wdata[XLEN-1] = is_irq_q;
      end
      S_W_TVAL: begin
        stall     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = A_MTVAL;
        csr_wdata = tval_q;
      end
      S_W_STAT: begin
        stall             = 1'b1;
        csr_we            = 1'b1;
        csr_addr          = A_MSTATUS;
        csr_wdata         = csr_rdata;
        csr_wdata[B_MPIE] = csr_rdata[B_MIE];
        csr_wdata[B_MIE]  = 1'b0;
        csr_wdata[12:11]  = 2'b11;
      end
      S_TVEC: begin
        csr_addr   = A_MTVEC;
        flush      = 1'b1;
        trap_taken = 1'b1;
        flush_pc   = {csr_rdata[XLEN-1:2], 2'b00};
        if (VECTORED && csr_rdata[1:0] == 2'b01 && is_irq_q)
          flush_pc = {csr_rdata[XLEN-1:2], 2'b00} + {{(XLEN-6){1'b0}}, code_q, 2'b00};
      end
      S_M_STAT: begin
        stall             = 1'b1;
        csr_we            = 1'b1;
        csr_addr          = A_MSTATUS;
        csr_wdata         = csr_rdata;
        csr_wdata[B_MIE]  = csr_rdata[B_MPIE];
        csr_wdata[B_MPIE] = 1'b1;
        csr_wdata[12:11]  = 2'b00;
      end
      S_M_EPC: begin
        csr_addr = A_MEPC;
        flush    = 1'b1;
        flush_pc = csr_rdata;
      end
      default: ;
    endcase
    if (reset) begin
      csr_we     = 1'b0;
      csr_addr   = 12'h000;
      csr_wdata  = '0;
      stall      = 1'b0;
      flush      = 1'b0;
      flush_pc   = '0;
      trap_taken = 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_trap_seq.sv
// tb/tb_ysyx_22041752_trap_seq.sv - scoreboard bench for the trap/return sequencer
module tb_ysyx_22041752_trap_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ecall, in_ebreak, in_illegal, in_mret;
  logic [63:0] in_pc, in_tval;
  logic [2:0]  irq_pending, irq_enable;
  logic        mstatus_mie;
  logic        ins_csr_we;
  logic [11:0] ins_csr_addr;
  logic [63:0] ins_csr_wdata;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata;
  logic        stall, flush, trap_taken;
  logic [63:0] flush_pc;

  always #5 clk = ~clk;

  ysyx_22041752_trap_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_ecall(in_ecall), .in_ebreak(in_ebreak), .in_illegal(in_illegal),
    .in_mret(in_mret), .in_tval(in_tval), .irq_pending(irq_pending),
    .irq_enable(irq_enable), .mstatus_mie(mstatus_mie),
    .ins_csr_we(ins_csr_we), .ins_csr_addr(ins_csr_addr),
    .ins_csr_wdata(ins_csr_wdata), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .stall(stall),
    .flush(flush), .flush_pc(flush_pc), .trap_taken(trap_taken)
  );

  // CSR file model: DUT writes win, bench preloads through a side port
  logic [63:0] csr_mem [0:4095];
  logic        tb_we = 1'b0;
  logic [11:0] tb_addr = 12'h0;
  logic [63:0] tb_data = 64'h0;
  assign csr_rdata = csr_mem[csr_addr];
  always @(posedge clk) begin
    if (csr_we)     csr_mem[csr_addr] <= csr_wdata;
    else if (tb_we) csr_mem[tb_addr]  <= tb_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_flush;
    bit          pt;
    logic [11:0] addr;
    logic [63:0] data;
    bit          trap;
    int          at;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [11:0] a, input logic [63:0] d, input bit pt = 0);
    exp_t e;
    e.is_flush = 0; e.pt = pt; e.addr = a; e.data = d; e.trap = 0; e.at = 0;
    sb.push_back(e);
  endtask

  task automatic push_f(input logic [63:0] pc, input bit trap, input int lat);
    exp_t e;
    e.is_flush = 1; e.pt = 0; e.addr = 0; e.data = pc; e.trap = trap; e.at = cyc + lat;
    sb.push_back(e);
  endtask

  // Monitor: compare every CSR write and redirect against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      exp_t e;
      bit exp_stall;
      exp_stall = (sb.size() > 0) && !sb[0].is_flush && !sb[0].pt;
      check("stall", stall, exp_stall);
      if (csr_we) begin
        if (sb.size() == 0) check("unexp_we", csr_we, 1'b0);
        else begin
          e = sb.pop_front();
          check("we_kind", 0, e.is_flush);
          check("we_addr", csr_addr, e.addr);
          check("we_data", csr_wdata, e.data);
        end
      end
      if (flush) begin
        if (sb.size() == 0) check("unexp_flush", flush, 1'b0);
        else begin
          e = sb.pop_front();
          check("fl_kind", 1, e.is_flush);
          check("fl_pc", flush_pc, e.data);
          check("fl_trap", trap_taken, e.trap);
          check("fl_cyc", cyc, e.at);
        end
      end
    end
  end

  task automatic setcsr(input logic [11:0] a, input logic [63:0] d);
    tb_addr = a; tb_data = d; tb_we = 1'b1;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_ecall = 0; in_ebreak = 0; in_illegal = 0; in_mret = 0;
    in_pc = 0; in_tval = 0; irq_pending = 0; irq_enable = 0; mstatus_mie = 0;
    ins_csr_we = 0; ins_csr_addr = 0; ins_csr_wdata = 0;
  endtask

  // Hold the event inputs through the whole sequence (incl. flush cycle),
  // scrambling pc/irqs after acceptance; only latched values may be used.
  task automatic fire();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) done = 1;
      else begin
        in_pc = in_pc ^ 64'h40;
        irq_pending = 3'b111;
      end
    end
    check("sb_timeout", sb.size(), 0);
    sb.delete();
    idle_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    in_valid = 1; ins_csr_we = 1; ins_csr_addr = 12'h340; ins_csr_wdata = 64'h55;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_we", csr_we, 0);
    check("rst_addr", csr_addr, 0);
    check("rst_wdata", csr_wdata, 0);
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_fpc", flush_pc, 0);
    check("rst_trap", trap_taken, 0);
    @(posedge clk); #1;
    idle_inputs();
    reset = 0;

    // ecall, direct mtvec
    setcsr(12'h300, 64'h8); setcsr(12'h305, 64'h8000_0000);
    in_valid = 1; in_pc = 64'h8000_0100; in_ecall = 1; mstatus_mie = 1;
    push_w(12'h341, 64'h8000_0100); push_w(12'h342, 64'hb);
    push_w(12'h343, 64'h0); push_w(12'h300, 64'h1880);
    push_f(64'h8000_0000, 1, 5);
    fire();

    // ecall with vectored mtvec: exceptions still go to base
    setcsr(12'h300, 64'h8); setcsr(12'h305, 64'h8000_0001);
    in_valid = 1; in_pc = 64'h8000_0110; in_ecall = 1; mstatus_mie = 1;
    push_w(12'h341, 64'h8000_0110); push_w(12'h342, 64'hb);
    push_w(12'h343, 64'h0); push_w(12'h300, 64'h1880);
    push_f(64'h8000_0000, 1, 5);
    fire();

    // MTI, vectored
    setcsr(12'h300, 64'h8); setcsr(12'h305, 64'h8000_0001);
    in_valid = 1; in_pc = 64'h8000_0200; irq_pending = 3'b001; irq_enable = 3'b001;
    mstatus_mie = 1; in_tval = 64'h77;
    push_w(12'h341, 64'h8000_0200); push_w(12'h342, 64'h8000_0000_0000_0007);
    push_w(12'h343, 64'h0); push_w(12'h300, 64'h1880);
    push_f(64'h8000_001C, 1, 5);
    fire();

    // illegal + ecall on the same instruction
    setcsr(12'h300, 64'h0); setcsr(12'h305, 64'h8000_0000);
    in_valid = 1; in_pc = 64'h8000_0300; in_illegal = 1; in_ecall = 1;
    in_tval = 64'hFFFF_FFFF;
    push_w(12'h341, 64'h8000_0300); push_w(12'h342, 64'h2);
    push_w(12'h343, 64'hFFFF_FFFF); push_w(12'h300, 64'h1800);
    push_f(64'h8000_0000, 1, 5);
    fire();

    // ebreak + ecall: ebreak wins
    setcsr(12'h300, 64'h8); setcsr(12'h305, 64'h8000_0040);
    in_valid = 1; in_pc = 64'h8000_0304; in_ebreak = 1; in_ecall = 1;
    push_w(12'h341, 64'h8000_0304); push_w(12'h342, 64'h3);
    push_w(12'h343, 64'h0); push_w(12'h300, 64'h1880);
    push_f(64'h8000_0040, 1, 5);
    fire();

    // mret restore
    setcsr(12'h341, 64'h8000_0204); setcsr(12'h300, 64'h1880);
    in_valid = 1; in_pc = 64'h8000_0400; in_mret = 1;
    push_w(12'h300, 64'h88);
    push_f(64'h8000_0204, 0, 2);
    fire();

    // MEI + MTI on an mret instruction: trap, no restore
    setcsr(12'h300, 64'h8); setcsr(12'h305, 64'h8000_0001);
    in_valid = 1; in_pc = 64'h8000_0500; in_mret = 1;
    irq_pending = 3'b101; irq_enable = 3'b111; mstatus_mie = 1;
    push_w(12'h341, 64'h8000_0500); push_w(12'h342, 64'h8000_0000_0000_000B);
    push_w(12'h343, 64'h0); push_w(12'h300, 64'h1880);
    push_f(64'h8000_002C, 1, 5);
    fire();

    // irq masked globally, and instruction write dropped when invalid
    in_valid = 1; in_pc = 64'h8000_0600; irq_pending = 3'b111; irq_enable = 3'b111;
    mstatus_mie = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mask_stall", stall, 0);
    end
    in_valid = 0; mstatus_mie = 1; ins_csr_we = 1; ins_csr_addr = 12'h340;
    @(negedge clk);
    check("inv_we", csr_we, 0);
    @(posedge clk); #1;
    idle_inputs();

    // reset in W_CAUSE, then a plain csrrw passes through
    setcsr(12'h300, 64'h8); setcsr(12'h305, 64'h8000_0000);
    in_valid = 1; in_pc = 64'h8000_0700; in_ecall = 1; mstatus_mie = 1;
    push_w(12'h341, 64'h8000_0700);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("rst_seq_we", csr_we, 0);
    check("rst_seq_flush", flush, 0);
    check("rst_seq_stall", stall, 0);
    check("rst_seq_sb", sb.size(), 0);
    in_valid = 1; ins_csr_we = 1; ins_csr_addr = 12'h340; ins_csr_wdata = 64'hDEAD_BEEF;
    push_w(12'h340, 64'hDEAD_BEEF, 1);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
